motor_pid_scheduler: RTL
========================

Name: motor_pid_scheduler

Overview:
- Time-multiplexed PID scheduler for N_CH motor channels that share one signed multiply/shift unit.
- Generates the sampling tick and latches every channel's encoder delta in the same cycle.
- Runs the error/P/I/D/update sequence per channel, in channel order 0..N_CH-1.
- Sits between the register file (targets, gains), the encoder counters and the PWM generators; replaces one full PID datapath per wheel.

Parameters:
- N_CH, 2, number of motor channels.
- BAND_WIDTH, 32, width of each pulse_width output.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- ONE_ROTATION_PULSE, 630, encoder pulses per rotation.
- SAMPLING_RATE, 100, control updates per second.
- GAIN_SHIFT, 16, fixed-point fraction bits of the gains.
- INTEG_LIMIT, 2**40, integral clamp magnitude; used only with PID_INTEG_CLAMP_EN.
- localparam RESOLUTION, 2*804*SAMPLING_RATE/ONE_ROTATION_PULSE, integer division (255 at defaults).
- localparam UPDATE_INTERVAL, CLK_FREQ/SAMPLING_RATE.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- target_rot_v  in  N_CH*32  signed target per channel; channel k is at [32k+31:32k].
- p_gain  in  N_CH*32  signed per-channel gain, Q(GAIN_SHIFT).
- i_gain  in  N_CH*32  same format as p_gain.
- d_gain  in  N_CH*32  same format as p_gain.
- rot_cnt  in  N_CH*32  free-running encoder counts.
- pulse_width  out  N_CH*BAND_WIDTH  low BAND_WIDTH bits of each channel's 64-bit accumulator.
- busy  out  1  high from LATCH through the last UPD.
- done  out  1  one-cycle pulse after the last channel's update.

Behaviour:
- Reset: cnt, FSM=IDLE, channel index, all per-channel registers (prev_cnt, delta, error, p_error, integ, pulse) and the term registers are zero; pulse_width=0, busy=0, done=0.
- Reset mid-sequence: aborts the sequence immediately, with no partial commit after reset.
- Tick generation: cnt counts 0..UPDATE_INTERVAL-1 and wraps; the tick is high when cnt==UPDATE_INTERVAL-1. Period is exactly UPDATE_INTERVAL cycles.
- Elaboration $error if UPDATE_INTERVAL <= 2+5*N_CH, so no tick can arrive while busy.
- IDLE: on tick go to LATCH.
- LATCH (all channels at once): delta[k] <= sign-extend-64(rot_cnt[k]-prev_cnt[k]), computed in 32-bit wrap arithmetic so counter wrap is handled; prev_cnt[k] <= rot_cnt[k]; ch <= 0.
- ERR: multiplier a=delta[ch], b=RESOLUTION, shift 0. p_error[ch] <= error[ch]; error[ch] <= target[ch] - product.
- P: a=p_gain, b=error[ch]; p_term <= result. integ[ch] <= integ[ch]+error[ch].
- I: a=i_gain, b=integ[ch] (the value updated in P); i_term <= result.
- D: a=d_gain, b=error[ch]-p_error[ch]; d_term <= result.
- UPD:
  - If target[ch]==0: pulse[ch] <= 0 and integ[ch] <= 0.
  - Else: pulse[ch] <= pulse[ch]+p_term+i_term+d_term.
  - If ch==N_CH-1, go to IDLE and pulse done; else ch++ and go to ERR.
- Multiplier: both operands sign-extended to 64 bits, full signed product, arithmetic shift right by the shift amount (GAIN_SHIFT in P/I/D), low 64 bits kept. All accumulators are 64-bit wrapping, with no saturation.
- Timing, with the tick in cycle T:
  - LATCH at T+1.
  - Channel k: ERR at T+2+5k, UPD at T+6+5k; pulse_width[k] changes at T+7+5k.
  - done is high in cycle T+2+5*N_CH.
- Inputs are sampled in the state that uses them; changing a gain mid-sequence affects only states not yet executed.

Optional Feature:
- Macro PID_INTEG_CLAMP_EN.
- Defined: in P, integ[ch] is saturated to [-INTEG_LIMIT, +INTEG_LIMIT] after the add (anti-windup).
- Undefined: integ wraps as a plain 64-bit add, and INTEG_LIMIT is unused.

Decomposition:
- Package motor_ctrl_pkg holds: the pid_sched_state_t enum (IDLE, LATCH, ERR, P, I, D, UPD), PI_FIXED=804, and the RESOLUTION computation as a function.
- One sub-module, pid_mul_shift: combinational signed 64x64 multiply plus arithmetic shift, instantiated exactly once. The FSM muxes its operands.

Test Plan:
- Defaults, N_CH=2, p_gain=65536, i=d=0, target0=2550, rot_cnt static: pulse_width0=2550 after the first tick and 5100 after the second.
- Same setup with rot_cnt0 advancing by 10 per period: error=2550-2550=0, so pulse_width0 stays constant.
- target1=0 with non-zero gains and history: pulse_width1 and integ1 are 0 after the next UPD, while channel 0 is unaffected.
- rot_cnt0 wraps from 0xFFFFFFFB to 0x00000005: delta=+10, not a large negative value.
- Latency check: done is high exactly 12 cycles after the tick; pulse_width0 changes at +7 and pulse_width1 at +12. rstn low during the D state of channel 0: all outputs are 0 and done does not appear.
- PID_INTEG_CLAMP_EN with INTEG_LIMIT=1000 and constant error 600: integ goes 600, 1000, 1000. Without the macro it goes 600, 1200, 1800.

Source files
------------

// File: rtl/motor_ctrl_pkg.sv
// Shared types and constants for the motor PID scheduler: FSM state encoding,
// fixed-point pi and the encoder-delta to speed scaling factor.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, LATCH, ERR, P, I, D, UPD} pid_sched_state_t;

  localparam int PI_FIXED = 804;

  // Scale factor from encoder pulses per sample period to target units.
  function automatic int calc_resolution(input int sampling_rate, input int one_rotation_pulse);
    return (2 * PI_FIXED * sampling_rate) / one_rotation_pulse;
  endfunction

  function automatic logic signed [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/pid_mul_shift.sv
// Shared signed 64x64 multiply with arithmetic right shift; purely combinational,
// zero latency, no flow control.
module pid_mul_shift (
  input  logic signed [63:0] a,
  input  logic signed [63:0] b,
  input  logic        [5:0]  shift,
  output logic signed [63:0] result
);

  logic signed [127:0] prod;
  logic signed [127:0] shifted;
  logic                unused_hi;

  assign prod      = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
  assign shifted   = prod >>> shift;
  assign result    = shifted[63:0];
  assign unused_hi = ^shifted[127:64];

endmodule

// File: rtl/motor_pid_scheduler.sv
// Time-multiplexed PID for N_CH motors: one sequence per sampling tick, 2+5*N_CH cycles.
// No backpressure; optional integral anti-windup clamp under PID_INTEG_CLAMP_EN.
module motor_pid_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int                 N_CH               = 2,
  parameter int                 BAND_WIDTH         = 32,
  parameter int                 CLK_FREQ           = 100_000_000,
  parameter int                 ONE_ROTATION_PULSE = 630,
  parameter int                 SAMPLING_RATE      = 100,
  parameter int                 GAIN_SHIFT         = 16,
  parameter logic signed [63:0] INTEG_LIMIT        = 64'sh0000_0100_0000_0000
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_CH*32-1:0]           target_rot_v,
  input  logic [N_CH*32-1:0]           p_gain,
  input  logic [N_CH*32-1:0]           i_gain,
  input  logic [N_CH*32-1:0]           d_gain,
  input  logic [N_CH*32-1:0]           rot_cnt,
  output logic [N_CH*BAND_WIDTH-1:0]   pulse_width,
  output logic                         busy,
  output logic                         done
);

  localparam int RESOLUTION      = calc_resolution(SAMPLING_RATE, ONE_ROTATION_PULSE);
  localparam int UPDATE_INTERVAL = CLK_FREQ / SAMPLING_RATE;
  localparam int CNT_W           = (UPDATE_INTERVAL > 1) ? $clog2(UPDATE_INTERVAL) : 1;
  localparam int CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  if (UPDATE_INTERVAL <= 2 + 5 * N_CH) begin : g_interval_check
    $error("motor_pid_scheduler: UPDATE_INTERVAL too short for N_CH channels");
  end

  pid_sched_state_t state, state_n;

  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic [CH_W-1:0]    ch;

  logic        [31:0] tgt      [N_CH];
  logic        [31:0] rot      [N_CH];
  logic        [31:0] kp       [N_CH];
  logic        [31:0] ki       [N_CH];
  logic        [31:0] kd       [N_CH];
  logic        [31:0] prev_cnt [N_CH];
  logic signed [63:0] lat_delta[N_CH];
  logic signed [63:0] delta    [N_CH];
  logic signed [63:0] error    [N_CH];
  logic signed [63:0] p_error  [N_CH];
  logic signed [63:0] integ    [N_CH];
  logic signed [63:0] pulse    [N_CH];

  logic signed [63:0] p_term, i_term, d_term;
  logic signed [63:0] integ_sum, integ_next;

  logic signed [63:0] mul_a, mul_b, mul_res;
  logic        [5:0]  mul_shift;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      tgt[k] = target_rot_v[32*k +: 32];
      rot[k] = rot_cnt[32*k +: 32];
      kp[k]  = p_gain[32*k +: 32];
      ki[k]  = i_gain[32*k +: 32];
      kd[k]  = d_gain[32*k +: 32];
      // 32-bit subtraction first so encoder counter wrap yields the true small delta
      lat_delta[k] = sext32(rot[k] - prev_cnt[k]);
    end
  end

  assign tick = (cnt == CNT_W'(UPDATE_INTERVAL - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mul_a     = '0;
    mul_b     = '0;
    mul_shift = '0;
    case (state)
      IDLE:  if (tick) state_n = LATCH;
      LATCH: state_n = ERR;
      ERR: begin
        mul_a   = delta[ch];
        mul_b   = 64'(RESOLUTION);
        state_n = P;
      end
      P: begin
        mul_a     = sext32(kp[ch]);
        mul_b     = error[ch];
        mul_shift = 6'(GAIN_SHIFT);
        state_n   = I;
      end
      I: begin
        mul_a     = sext32(ki[ch]);
        mul_b     = integ[ch];
        mul_shift = 6'(GAIN_SHIFT);
        state_n   = D;
      end
      D: begin
        mul_a     = sext32(kd[ch]);
        mul_b     = error[ch] - p_error[ch];
        mul_shift = 6'(GAIN_SHIFT);
        state_n   = UPD;
      end
      UPD:     state_n = (ch == LAST_CH) ? IDLE : ERR;
      default: state_n = IDLE;
    endcase
  end

  pid_mul_shift u_mul (
    .a      (mul_a),
    .b      (mul_b),
    .shift  (mul_shift),
    .result (mul_res)
  );

  assign integ_sum = integ[ch] + error[ch];

`ifdef PID_INTEG_CLAMP_EN
  always_comb begin
    integ_next = integ_sum;
    if (integ_sum > INTEG_LIMIT)       integ_next = INTEG_LIMIT;
    else if (integ_sum < -INTEG_LIMIT) integ_next = -INTEG_LIMIT;
  end
`else
  logic unused_limit;
  assign unused_limit = ^INTEG_LIMIT;
  assign integ_next   = integ_sum;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      ch     <= '0;
      done   <= 1'b0;
      p_term <= '0;
      i_term <= '0;
      d_term <= '0;
      for (int k = 0; k < N_CH; k++) begin
        prev_cnt[k] <= '0;
        delta[k]    <= '0;
        error[k]    <= '0;
        p_error[k]  <= '0;
        integ[k]    <= '0;
        pulse[k]    <= '0;
      end
    end else begin
      cnt  <= tick ? '0 : cnt + CNT_W'(1);
      done <= 1'b0;
      case (state)
        LATCH: begin
          for (int k = 0; k < N_CH; k++) begin
            delta[k]    <= lat_delta[k];
            prev_cnt[k] <= rot[k];
          end
          ch <= '0;
        end
        ERR: begin
          p_error[ch] <= error[ch];
          error[ch]   <= sext32(tgt[ch]) - mul_res;
        end
        P: begin
          p_term    <= mul_res;
          integ[ch] <= integ_next;
        end
        I: i_term <= mul_res;
        D: d_term <= mul_res;
        UPD: begin
          if (tgt[ch] == 32'd0) begin
            pulse[ch] <= '0;
            integ[ch] <= '0;
          end else begin
            pulse[ch] <= pulse[ch] + p_term + i_term + d_term;
          end
          if (ch == LAST_CH) done <= 1'b1;
          else               ch   <= ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign pulse_width[k*BAND_WIDTH +: BAND_WIDTH] = pulse[k][BAND_WIDTH-1:0];
  end

endmodule
